// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths, reset PC, redirect-select encoding.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package instruction_fetch_queue_pkg;

   localparam int unsigned NB_INSTR_DEF = 32;
   localparam int unsigned NB_INM_I_DEF = 16;
   localparam int unsigned NB_INM_J_DEF = 26;
   localparam int unsigned RESET_PC_DEF = 0;

   typedef enum logic [1:0] {
      SEL_NONE     = 2'd0,
      SEL_BRANCH   = 2'd1,
      SEL_JUMP_INM = 2'd2,
      SEL_JUMP_RS  = 2'd3
   } redirect_sel_e;

   // Fixed priority: register jump beats immediate jump beats branch.
   function automatic redirect_sel_e redirect_select(input logic branch,
                                                     input logic jump_inm,
                                                     input logic jump_rs);
      if (jump_rs)       return SEL_JUMP_RS;
      else if (jump_inm) return SEL_JUMP_INM;
      else if (branch)   return SEL_BRANCH;
      else               return SEL_NONE;
   endfunction

   // True when two or more redirect sources are raised together.
   function automatic logic multi_redirect(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/instruction_fetch_queue_fifo.sv
// Generic synchronous FIFO with flush; head is read combinationally from the storage array.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full (unless popping), pop ignored when empty; caller owns the credit.
// Ports: clk_i/rst_i (sync, active-high), flush_i empties the queue, push_i/push_dat_i write the tail,
//        pop_i advances the head, head_dat_o/full_o/empty_o/count_o report state.
module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];

   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction prefetch queue: issues PC reads, queues returned instructions, handles branch/jump redirects.
// Latency: fetch issues 1 cycle after reset/redirect; the response is bypassed to decode the cycle it returns.
// Backpressure: i_instr_ready stalls decode; fetch only issues while queued + in-flight < QUEUE_DEPTH.
// Ports: i_clock/i_reset/i_valid control; o_imem_addr/o_imem_req/i_imem_data memory side;
//        o_instr_valid/i_instr_ready/o_instruction/o_pc_plus4 decode side;
//        i_branch/i_jump_inm/i_jump_rs/i_redirect_pc/i_inm_i/i_inm_j/i_rs redirect side, o_redirect_err.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
#(
   parameter int unsigned         NB_ADDR     = 32,
   parameter int unsigned         NB_INSTR    = NB_INSTR_DEF,
   parameter int unsigned         NB_INM_I    = NB_INM_I_DEF,
   parameter int unsigned         NB_INM_J    = NB_INM_J_DEF,
   parameter int unsigned         QUEUE_DEPTH = 4,
   parameter logic [NB_ADDR-1:0]  RESET_PC    = NB_ADDR'(RESET_PC_DEF)
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   output logic [NB_ADDR-1:0]  o_imem_addr,
   output logic                o_imem_req,
   input  logic [NB_INSTR-1:0] i_imem_data,
   output logic                o_instr_valid,
   input  logic                i_instr_ready,
   output logic [NB_INSTR-1:0] o_instruction,
   output logic [NB_ADDR-1:0]  o_pc_plus4,
   input  logic                i_branch,
   input  logic                i_jump_inm,
   input  logic                i_jump_rs,
   input  logic [NB_ADDR-1:0]  i_redirect_pc,
   input  logic [NB_INM_I-1:0] i_inm_i,
   input  logic [NB_INM_J-1:0] i_inm_j,
   input  logic [NB_ADDR-1:0]  i_rs,
   output logic                o_redirect_err
);

   localparam int unsigned CW       = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned NB_JHI   = NB_ADDR - NB_INM_J - 2;
   localparam int unsigned NB_ENTRY = NB_ADDR + NB_INSTR;

   logic [NB_ADDR-1:0]  pc_q, pc_d, req_addr_q, req_addr_d;
   logic                inflight_q, inflight_d;
   logic                any_redirect, redirect, fetch, credit;
   logic                head_vld, bypass, pop, push, fifo_pop;
   redirect_sel_e       sel;
   logic [NB_ADDR-1:0]  redir_pc4, br_offset, target;
   logic [NB_ENTRY-1:0] resp_entry, fifo_head, head_entry;
   logic                fifo_full, fifo_empty;
   logic [CW-1:0]       fifo_count;

   // ---------------- redirect target ----------------
   assign any_redirect = i_branch | i_jump_inm | i_jump_rs;
   assign redirect     = i_valid && any_redirect && !i_reset;
   assign sel          = redirect_select(i_branch, i_jump_inm, i_jump_rs);
   assign redir_pc4    = i_redirect_pc + NB_ADDR'(4);
   assign br_offset    = {{(NB_ADDR-NB_INM_I-2){i_inm_i[NB_INM_I-1]}}, i_inm_i, 2'b00};

   always_comb begin
      target = pc_q;
      unique case (sel)
         SEL_JUMP_RS:  target = i_rs;
         SEL_JUMP_INM: target = {redir_pc4[NB_ADDR-1 -: NB_JHI], i_inm_j, 2'b00};
         SEL_BRANCH:   target = redir_pc4 + br_offset;
         default:      target = pc_q;
      endcase
   end

   assign o_redirect_err = i_valid && !i_reset && multi_redirect(i_branch, i_jump_inm, i_jump_rs);

   // ---------------- fetch issue ----------------
   // Every outstanding request owns a queue slot, so a response can always be written.
   assign credit = !fifo_full && ((fifo_count + CW'(inflight_q)) < CW'(QUEUE_DEPTH));
   assign fetch  = i_valid && !i_reset && !any_redirect && credit;

   assign o_imem_req  = fetch;
   assign o_imem_addr = pc_q;

   // ---------------- queue / bypass ----------------
   // A response arriving into an empty queue is presented directly so a redirect costs only two cycles.
   assign resp_entry = {req_addr_q, i_imem_data};
   assign bypass     = fifo_empty && inflight_q;
   assign head_vld   = !fifo_empty || inflight_q;
   assign head_entry = fifo_empty ? resp_entry : fifo_head;
   assign pop        = head_vld && i_instr_ready && i_valid && !redirect;
   assign fifo_pop   = pop && !fifo_empty;
   // Responses are captured even while i_valid is low; a redirect discards them.
   assign push       = inflight_q && !redirect && !i_reset && !(bypass && pop);

   assign o_instr_valid = head_vld;
   assign o_instruction = head_vld ? head_entry[NB_INSTR-1:0] : '0;
   assign o_pc_plus4    = head_vld ? (head_entry[NB_ENTRY-1:NB_INSTR] + NB_ADDR'(4)) : '0;

   sync_fifo #(
      .WIDTH (NB_ENTRY),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i      (i_clock),
      .rst_i      (i_reset),
      .flush_i    (redirect),
      .push_i     (push),
      .push_dat_i (resp_entry),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   // ---------------- PC / in-flight state ----------------
   always_comb begin
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      inflight_d = fetch;
      if (redirect) begin
         pc_d = target;
      end else if (fetch) begin
         pc_d       = pc_q + NB_ADDR'(4);
         req_addr_d = pc_q;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

   localparam logic [31:0] K      = 32'h5A5A_C3C3;
   localparam logic [31:0] POISON = 32'hDEAD_DEAD;

   logic        clk;
   logic        i_reset, i_valid, i_instr_ready;
   logic        i_branch, i_jump_inm, i_jump_rs;
   logic [31:0] i_redirect_pc, i_rs, i_imem_data;
   logic [15:0] i_inm_i;
   logic [25:0] i_inm_j;
   logic [31:0] o_imem_addr, o_instruction, o_pc_plus4;
   logic        o_imem_req, o_instr_valid, o_redirect_err;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   logic [31:0] e;

   instruction_fetch_queue dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_valid       (i_valid),
      .o_imem_addr   (o_imem_addr),
      .o_imem_req    (o_imem_req),
      .i_imem_data   (i_imem_data),
      .o_instr_valid (o_instr_valid),
      .i_instr_ready (i_instr_ready),
      .o_instruction (o_instruction),
      .o_pc_plus4    (o_pc_plus4),
      .i_branch      (i_branch),
      .i_jump_inm    (i_jump_inm),
      .i_jump_rs     (i_jump_rs),
      .i_redirect_pc (i_redirect_pc),
      .i_inm_i       (i_inm_i),
      .i_inm_j       (i_inm_j),
      .i_rs          (i_rs),
      .o_redirect_err(o_redirect_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: one-cycle read latency, content is a function of the address.
   always @(posedge clk) i_imem_data <= o_imem_req ? (o_imem_addr ^ K) : POISON;

   wire accept = o_instr_valid && i_instr_ready && i_valid && !(i_branch || i_jump_inm || i_jump_rs);

   task automatic clear_inputs;
      i_valid = 1'b1; i_instr_ready = 1'b0;
      i_branch = 1'b0; i_jump_inm = 1'b0; i_jump_rs = 1'b0;
      i_redirect_pc = '0; i_rs = '0; i_inm_i = '0; i_inm_j = '0;
   endtask

   task automatic do_reset;
      i_reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      clear_inputs();
      i_branch = 1'b1; i_jump_rs = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (o_instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_instr_valid); end
      n_cmp++; if (o_instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", o_instruction); end
      n_cmp++; if (o_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL rst_pc4: got %h want 0", o_pc_plus4); end
      n_cmp++; if (o_imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", o_imem_req); end
      n_cmp++; if (o_redirect_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", o_redirect_err); end
      @(negedge clk);
      i_reset = 1'b0; i_branch = 1'b0; i_jump_rs = 1'b0;
      #1;
      n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0})
         begin n_err++; $display("FAIL rst_first_fetch: got req=%b addr=%h want 1/0", o_imem_req, o_imem_addr); end
      @(negedge clk);
   endtask

   task automatic test_stream;
      int first, last;
      first = -1; last = -1;
      do_reset();
      i_instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         #1;
         if (accept) begin
            if (first < 0) first = c;
            last = c;
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL stream_order: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_timeout: %0d left want 0", exp_q.size()); end
      n_cmp++; if (first != 1) begin n_err++; $display("FAIL stream_first_cycle: got %0d want 1", first); end
      n_cmp++; if (last != 10) begin n_err++; $display("FAIL stream_throughput: last at %0d want 10", last); end
   endtask

   task automatic test_stall;
      int nreq;
      nreq = 0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         if (o_imem_req) nreq++;
         if (c == 9) begin
            n_cmp++; if ({o_imem_req, o_instr_valid} !== 2'b01)
               begin n_err++; $display("FAIL stall_idle: req=%b valid=%b want 0/1", o_imem_req, o_instr_valid); end
         end
         @(negedge clk);
      end
      n_cmp++; if (nreq != 4) begin n_err++; $display("FAIL stall_reqs: got %0d want 4", nreq); end
      i_instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         #1;
         if (accept) begin
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL stall_drain: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_timeout: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_branch;
      do_reset();
      i_instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         if (c == 5) begin i_branch = 1'b1; i_redirect_pc = 32'h100; i_inm_i = 16'hFFFE; end
         if (c == 6) i_branch = 1'b0;
         #1;
         if (c == 5) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) exp_q.push_back(32'h0FC + 32'(i * 4));
         end
         if (c == 6) begin
            n_cmp++; if (o_instr_valid !== 1'b0) begin n_err++; $display("FAIL br_stale: valid=%b pc4=%h want valid 0", o_instr_valid, o_pc_plus4); end
            n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0FC})
               begin n_err++; $display("FAIL br_target: req=%b addr=%h want 1/0fc", o_imem_req, o_imem_addr); end
         end
         if (c == 7) begin
            n_cmp++; if ({o_instr_valid, o_pc_plus4} !== {1'b1, 32'h100})
               begin n_err++; $display("FAIL br_latency: valid=%b pc4=%h want 1/100", o_instr_valid, o_pc_plus4); end
         end
         if (accept) begin
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL br_order: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL br_timeout: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_jump;
      do_reset();
      i_instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         if (c == 3) begin i_jump_inm = 1'b1; i_redirect_pc = 32'h1000_0010; i_inm_j = 26'h40; end
         if (c == 4) i_jump_inm = 1'b0;
         if (c == 9) begin i_jump_rs = 1'b1; i_rs = 32'h200; end
         if (c == 10) i_jump_rs = 1'b0;
         #1;
         if (c == 3) begin
            exp_q.delete();
            for (int i = 0; i < 9; i++) exp_q.push_back(32'h1000_0100 + 32'(i * 4));
         end
         if (c == 9) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(i * 4));
         end
         if (c == 4) begin
            n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h1000_0100})
               begin n_err++; $display("FAIL jimm_target: req=%b addr=%h want 1/10000100", o_imem_req, o_imem_addr); end
         end
         if (c == 10) begin
            n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h200})
               begin n_err++; $display("FAIL jrs_target: req=%b addr=%h want 1/200", o_imem_req, o_imem_addr); end
         end
         if (accept) begin
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL jump_order: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL jump_timeout: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_redirect_err;
      do_reset();
      i_instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         if (c == 3) begin i_branch = 1'b1; i_jump_rs = 1'b1; i_rs = 32'h300; i_redirect_pc = 32'h100; i_inm_i = 16'h0005; end
         if (c == 4) begin i_branch = 1'b0; i_jump_rs = 1'b0; end
         if (c == 8) begin i_branch = 1'b1; i_jump_inm = 1'b1; i_redirect_pc = 32'h2000_0000; i_inm_j = 26'h10; end
         if (c == 9) begin i_branch = 1'b0; i_jump_inm = 1'b0; end
         #1;
         if (c == 3) begin
            exp_q.delete();
            for (int i = 0; i < 5; i++) exp_q.push_back(32'h300 + 32'(i * 4));
         end
         if (c == 8) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) exp_q.push_back(32'h2000_0040 + 32'(i * 4));
         end
         if (c == 2 || c == 4 || c == 9) begin
            n_cmp++; if (o_redirect_err !== 1'b0) begin n_err++; $display("FAIL err_idle c%0d: got %b want 0", c, o_redirect_err); end
         end
         if (c == 3 || c == 8) begin
            n_cmp++; if (o_redirect_err !== 1'b1) begin n_err++; $display("FAIL err_pulse c%0d: got %b want 1", c, o_redirect_err); end
         end
         if (c == 4) begin
            n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h300})
               begin n_err++; $display("FAIL err_rs_wins: req=%b addr=%h want 1/300", o_imem_req, o_imem_addr); end
         end
         if (c == 9) begin
            n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h2000_0040})
               begin n_err++; $display("FAIL err_jimm_wins: req=%b addr=%h want 1/20000040", o_imem_req, o_imem_addr); end
         end
         if (accept) begin
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL err_order: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL err_timeout: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int c = 0; c < 40 && (c < 6 || exp_q.size() > 0); c++) begin
         if (c == 4) i_reset = 1'b1;
         if (c == 5) begin i_reset = 1'b0; i_instr_ready = 1'b1; end
         #1;
         if (c == 5) begin
            n_cmp++; if ({o_instr_valid, o_instruction, o_pc_plus4} !== {1'b0, 32'h0, 32'h0})
               begin n_err++; $display("FAIL mid_rst_out: valid=%b instr=%h pc4=%h want 0/0/0", o_instr_valid, o_instruction, o_pc_plus4); end
            n_cmp++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0})
               begin n_err++; $display("FAIL mid_rst_fetch: req=%b addr=%h want 1/0", o_imem_req, o_imem_addr); end
            for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
         end
         if (accept) begin
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL mid_rst_order: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_rst_timeout: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_valid_low;
      do_reset();
      i_instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         i_valid = !(c >= 1 && c <= 3);
         #1;
         if (c == 1 || c == 3) begin
            n_cmp++; if (o_imem_req !== 1'b0) begin n_err++; $display("FAIL hold_no_fetch c%0d: req=%b want 0", c, o_imem_req); end
         end
         if (c == 3) begin
            n_cmp++; if ({o_instr_valid, o_pc_plus4} !== {1'b1, 32'h4})
               begin n_err++; $display("FAIL hold_captured: valid=%b pc4=%h want 1/4", o_instr_valid, o_pc_plus4); end
         end
         if (accept) begin
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (o_pc_plus4 !== e + 32'd4 || o_instruction !== (e ^ K)) begin
               n_err++; $display("FAIL hold_order: pc4=%h instr=%h want pc4=%h instr=%h", o_pc_plus4, o_instruction, e + 32'd4, e ^ K);
            end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hold_timeout: %0d left want 0", exp_q.size()); end
   endtask

   initial begin
      i_reset = 1'b1;
      clear_inputs();
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_jump();
      test_redirect_err();
      test_reset_mid();
      test_valid_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
